// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions: default polynomial/init value, byte width and
// the frame-checker FSM state encoding.
package crc_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;
  localparam logic [BYTE_W-1:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/crc8_frame_checker_if.sv
// Byte-stream handshake into the frame checker.
//   in_data  : frame byte
//   in_valid : in_data is valid
//   in_last  : in_data is the final (CRC) byte of the frame
//   in_ready : checker can accept a byte this cycle
// master = byte source, slave = checker.
interface crc8_frame_checker_if;
  import crc_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/crc8_step.sv
// Combinational one-byte CRC-8 update, MSB-first, non-reflected.
//   crc_in  : running CRC
//   data_in : byte to absorb
//   crc_out : CRC after absorbing data_in
module crc8_step
  import crc_pkg::*;
#(
  parameter logic [BYTE_W-1:0] POLY = CRC8_POLY
) (
  input  logic [BYTE_W-1:0] crc_in,
  input  logic [BYTE_W-1:0] data_in,
  output logic [BYTE_W-1:0] crc_out
);

  logic [BYTE_W-1:0] c;

  // XOR the byte in, then eight shift/conditional-XOR steps.
  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[BYTE_W-1] ? ({c[BYTE_W-2:0], 1'b0} ^ POLY) : {c[BYTE_W-2:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker. Runs CRC over every byte of a frame
// including the trailing check byte; a zero residue means the frame is good.
//   clk, rst_n : clock, async active-low reset
//   in_bus     : byte stream (data/valid/last in, ready out)
//   frame_done : one-cycle pulse when a frame result is presented
//   frame_ok   : last frame had zero residue and no length overrun
//   frame_len  : byte count of last frame incl. CRC byte (saturated)
//   len_err    : last frame exceeded 2^LEN_W-1 bytes
//   err_cnt    : saturating count of failed frames since reset
module crc8_frame_checker
  import crc_pkg::*;
#(
  parameter logic [BYTE_W-1:0] POLY  = CRC8_POLY,
  parameter logic [BYTE_W-1:0] INIT  = CRC8_INIT,
  parameter int unsigned       LEN_W = 8,
  parameter int unsigned       ERR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  crc8_frame_checker_if.slave  in_bus,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 len_err,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              done_d;
  logic              clear_c;
  logic              accept_c;
  logic [BYTE_W-1:0] crc_q, crc_nxt;
  logic [LEN_W-1:0]  cnt_q, len_nxt;
  logic              ovf_q, ovf_nxt;
  logic              cnt_sat_c;
  logic              ok_c;

  assign in_bus.in_ready = ready_q;
  assign accept_c        = in_bus.in_valid && ready_q;

  crc8_step #(.POLY(POLY)) u_step (
    .crc_in  (crc_q),
    .data_in (in_bus.in_data),
    .crc_out (crc_nxt)
  );

  // Frame length / overrun / verdict as they will be after this byte.
  assign cnt_sat_c = (cnt_q == LEN_MAX);
  assign len_nxt   = cnt_sat_c ? cnt_q : cnt_q + LEN_W'(1);
  assign ovf_nxt   = ovf_q | cnt_sat_c;
  assign ok_c      = (crc_nxt == '0) && !ovf_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = in_bus.in_last ? REPORT : RECV;
      RECV:    if (accept_c && in_bus.in_last) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs; ready/done are registered so they line up with REPORT.
  always_comb begin
    ready_d = 1'b1;
    done_d  = 1'b0;
    clear_c = 1'b0;
    if (state_d == REPORT) begin
      ready_d = 1'b0;
      done_d  = 1'b1;
    end
    if (state_q == REPORT) clear_c = 1'b1;
  end

  // Running CRC / count; re-armed to INIT during the report bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= INIT;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept_c) begin
      crc_q <= crc_nxt;
      cnt_q <= len_nxt;
      ovf_q <= ovf_nxt;
    end else if (clear_c) begin
      crc_q <= INIT;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  // Result registers, loaded on the edge that enters REPORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b1;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      len_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      ready_q    <= ready_d;
      frame_done <= done_d;
      if (done_d) begin
        frame_ok  <= ok_c;
        frame_len <= len_nxt;
        len_err   <= ovf_nxt;
        if (!ok_c && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Receive-side counterpart of the CRC-8 generator path. The block accepts a byte stream framed by a last-byte flag, runs CRC-8 over every byte of the frame including the trailing check byte, and reports pass/fail per frame. It sits between the byte source (UART/link receiver or test driver) and the packet consumer, and keeps a saturating count of failed frames.

## Interface
Parameters:
- POLY, 8'h07, CRC-8 generator polynomial (MSB-first, non-reflected)
- INIT, 8'h00, CRC register value at frame start
- LEN_W, 8, width of frame byte counter; max legal frame = 2^LEN_W-1 bytes
- ERR_W, 16, width of failed-frame counter

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- in_data  in  8  frame byte; don't-care when in_valid=0
- in_valid  in  1  in_data is valid
- in_last  in  1  qualifies in_data as the frame's final byte (the CRC byte)
- in_ready  out  1  block can accept a byte this cycle
- frame_done  out  1  one-cycle pulse: frame result valid
- frame_ok  out  1  result of last frame: CRC residue zero and no overrun
- frame_len  out  LEN_W  byte count of last frame, including CRC byte (saturated)
- len_err  out  1  last frame exceeded 2^LEN_W-1 bytes
- err_cnt  out  ERR_W  number of failed frames since reset, saturating

## Operation
- Transfer: byte accepted on CLK rising edge when in_valid && in_ready. Nothing else changes state.
- CRC update per accepted byte: crc ^= in_data, then 8 MSB-first shift steps (shift left; if shifted-out bit was 1, XOR POLY). Running CRC over payload+check byte; frame passes iff final crc == 8'h00 (no xorout, so residue is zero).
- FSM states: IDLE, RECV, REPORT.
  - IDLE: crc=INIT, cnt=0, in_ready=1. Accept with in_last=0 -> RECV; accept with in_last=1 -> REPORT (1-byte frame).
  - RECV: in_ready=1. Each accept updates crc, cnt. Accept with in_last=1 -> REPORT.
  - REPORT: in_ready=0; frame_done=1 for exactly this cycle; frame_ok/frame_len/len_err updated; err_cnt += 1 if !frame_ok (saturate at all-ones). Unconditional -> IDLE.
- Length: cnt increments per accepted byte, saturates at 2^LEN_W-1; a byte accepted while saturated sets an overrun flag. Overrun frame still consumed to in_last, reports frame_ok=0, len_err=1, frame_len=all-ones.
- frame_ok, frame_len, len_err hold their value until next REPORT.
- in_valid low inside a frame: idle gap, no state change; no timeout.

## Timing
- Reset values: in_ready=1, frame_done=0, frame_ok=0, frame_len=0, len_err=0, err_cnt=0; FSM=IDLE, crc=INIT.
- Latency: last byte accepted at edge N -> frame_done/frame_ok valid in cycle N+1 -> in_ready high again at N+2. One bubble cycle per frame.
- Throughput: one byte per cycle within a frame.
- in_ready does not depend combinationally on in_valid.
- RST_N asserted mid-frame: partial frame discarded, no frame_done, err_cnt cleared.
- err_cnt at all-ones plus another failure: stays all-ones.

## Structure
- Package crc_pkg: CRC8_POLY, CRC8_INIT constants; FSM state encoding (IDLE/RECV/REPORT).
- Sub-module crc8_step: combinational 8-bit next-CRC function (crc_in, data_in -> crc_out), parameterised by POLY; shared with the generator side so both ends use one implementation.

## Test plan
- Reset, then frame 01 02 03 04 E3 (E3 on in_last), in_valid continuous -> frame_done one cycle after E3, frame_ok=1, frame_len=5, err_cnt=0; in_ready low only in REPORT cycle.
- Same frame with check byte E2 -> frame_ok=0, frame_len=5, err_cnt=1; following good frame -> frame_ok=1, err_cnt stays 1.
- ASCII "123456789" + F4 with random in_valid gaps -> frame_ok=1, frame_len=10.
- Single-byte frame 00 with in_last=1 in IDLE -> frame_ok=1, frame_len=1; single byte 07 -> frame_ok=0.
- LEN_W=3: 8-byte frame -> len_err=1, frame_len=7, frame_ok=0, err_cnt increments; next 5-byte good frame clears len_err.
- RST_N pulsed after 01 02 accepted -> no frame_done; then full good frame -> frame_ok=1, frame_len=5, err_cnt=0.
